pc_gen: RTL and testbench

Parametrised fetch-PC generator for the front end, replacing the fixed single-source PC register. It selects among N prioritised redirect channels, a latched pending redirect, and the sequential +2/+4 step. It issues fetch addresses to the icache over a valid/ready handshake. Redirects that arrive while fetch cannot advance are held in a pending register, never dropped.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_redir_arb.sv | 33 +++
 rtl/pc_gen.sv | 86 ++++++++
 tb/tb_pc_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: default widths, reset vector,
// state encodings and the sequential step helper.
package pc_gen_pkg;

    localparam int XLEN = 64;
    localparam logic [63:0] PC_RESET_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        PC_ST_BOOT = 2'd0,
        PC_ST_RUN  = 2'd1,
        PC_ST_HOLD = 2'd2
    } pc_state_e;

    // Sequential increment: 2 for a 16-bit instruction when compressed is enabled, else 4.
    function automatic logic [2:0] seq_step(input logic c_ext, input logic compressed);
        return (c_ext && compressed) ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: the lowest asserted channel index wins, and
// its target is aligned to the instruction granule. Purely combinational.
module pc_redir_arb
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W    = XLEN,
    parameter int NUM_REDIR = 3,
    parameter bit C_EXT     = 1'b1
) (
    input  logic [NUM_REDIR-1:0]        valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] targets,
    output logic                        hit,
    output logic [ADDR_W-1:0]           target
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = C_EXT ? ~ADDR_W'(1) : ~ADDR_W'(3);

    logic [ADDR_W-1:0] raw;

    // Walk from the lowest priority upward so channel 0 is written last and wins.
    always_comb begin
        raw = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (valid[k]) begin
                raw = targets[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign hit    = |valid;
    assign target = raw & ALIGN_MASK;

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: live redirects, a held pending redirect, the reset vector
// and the sequential step feed the icache request over a valid/ready handshake.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = XLEN,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_ADDR),
    parameter int                NUM_REDIR  = 3,
    parameter bit                C_EXT      = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc_i,
    input  logic                        stall_i,
    input  logic                        is_compressed_i,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [ADDR_W-1:0]           req_addr_o,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        redir_pending_o
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              live_hit;
    logic [ADDR_W-1:0] live_target;
    logic              fire;

    pc_redir_arb #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR),
        .C_EXT     (C_EXT)
    ) u_arb (
        .valid   (redir_valid_i),
        .targets (redir_pc_i),
        .hit     (live_hit),
        .target  (live_target)
    );

    assign req_valid_o     = ~stall_i & ~rst;
    assign fire            = req_valid_o & req_ready_i;
    assign pc_o            = pc_q;
    assign redir_pending_o = (state_q == PC_ST_HOLD);

    always_comb begin
        if (live_hit) begin
            req_addr_o = live_target;
        end else if (state_q == PC_ST_HOLD) begin
            req_addr_o = pend_q;
        end else if (state_q == PC_ST_BOOT) begin
            req_addr_o = RESET_ADDR;
        end else begin
            req_addr_o = pc_q + ADDR_W'(seq_step(C_EXT, is_compressed_i));
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        if (fire) begin
            state_d = PC_ST_RUN;
            pc_d    = req_addr_o;
            pend_d  = '0;
        end else if (live_hit) begin
            // Newest redirect replaces any older pending one regardless of channel.
            state_d = PC_ST_HOLD;
            pend_d  = live_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_ST_BOOT;
            pc_q    <= RESET_ADDR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with compressed support, one without,
// driven by the same stimulus and checked against hand-computed addresses.
module tb_pc_gen;

    localparam int AW = 64;
    localparam int NR = 3;
    localparam logic [AW-1:0] RST_A = 64'h0000_0000_8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     redir_valid;
    logic [NR*AW-1:0]  redir_pc;
    logic              stall;
    logic              is_compressed;
    logic              req_ready;
    logic              req_valid, req_valid4;
    logic [AW-1:0]     req_addr, req_addr4;
    logic [AW-1:0]     pc, pc4;
    logic              pending, pending4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(AW), .RESET_ADDR(RST_A), .NUM_REDIR(NR), .C_EXT(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .redir_valid_i   (redir_valid),
        .redir_pc_i      (redir_pc),
        .stall_i         (stall),
        .is_compressed_i (is_compressed),
        .req_valid_o     (req_valid),
        .req_ready_i     (req_ready),
        .req_addr_o      (req_addr),
        .pc_o            (pc),
        .redir_pending_o (pending)
    );

    pc_gen #(.ADDR_W(AW), .RESET_ADDR(RST_A), .NUM_REDIR(NR), .C_EXT(1'b0)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .redir_valid_i   (redir_valid),
        .redir_pc_i      (redir_pc),
        .stall_i         (stall),
        .is_compressed_i (is_compressed),
        .req_valid_o     (req_valid4),
        .req_ready_i     (req_ready),
        .req_addr_o      (req_addr4),
        .pc_o            (pc4),
        .redir_pending_o (pending4)
    );

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input int ch, input logic [AW-1:0] target);
        redir_valid     = '0;
        redir_valid[ch] = 1'b1;
        redir_pc[ch*AW +: AW] = target;
    endtask

    initial begin
        rst = 1'b1; redir_valid = '0; redir_pc = '0;
        stall = 1'b0; is_compressed = 1'b0; req_ready = 1'b0;
        #3;
        chk("rst_valid",   AW'(req_valid), 64'd0);
        chk("rst_addr",    req_addr, RST_A);
        chk("rst_pc",      pc, RST_A);
        chk("rst_pending", AW'(pending), 64'd0);

        #4;
        rst = 1'b0; req_ready = 1'b1;
        #1;
        chk("boot_valid", AW'(req_valid), 64'd1);
        chk("seq0_addr",  req_addr, 64'h8000_0000);
        tick();
        chk("seq1_addr", req_addr, 64'h8000_0004);
        chk("seq1_pc",   pc, 64'h8000_0000);
        tick();
        chk("seq2_addr", req_addr, 64'h8000_0008);
        chk("seq2_pc",   pc, 64'h8000_0004);

        redir(0, 64'h8000_0010);
        #1;
        chk("redir0_addr", req_addr, 64'h8000_0010);
        tick();
        redir_valid = '0; is_compressed = 1'b1;
        #1;
        chk("cmp_pc",     pc, 64'h8000_0010);
        chk("cmp_addr",   req_addr, 64'h8000_0012);
        chk("nocmp_addr", req_addr4, 64'h8000_0014);
        tick();
        chk("cmp_pc2",   pc, 64'h8000_0012);
        chk("nocmp_pc2", pc4, 64'h8000_0014);
        is_compressed = 1'b0;

        redir_valid = 3'b110;
        redir_pc[1*AW +: AW] = 64'h8000_1000;
        redir_pc[2*AW +: AW] = 64'h8000_2000;
        #1;
        chk("prio_addr", req_addr, 64'h8000_1000);
        redir_pc[1*AW +: AW] = 64'h8000_1003;
        #1;
        chk("align2_addr", req_addr, 64'h8000_1002);
        chk("align4_addr", req_addr4, 64'h8000_1000);
        tick();
        redir_valid = '0;
        #1;
        chk("align_pc", pc, 64'h8000_1002);

        stall = 1'b1;
        redir(1, 64'h8000_3000);
        #1;
        chk("stall_valid",   AW'(req_valid), 64'd0);
        chk("stall_addr",    req_addr, 64'h8000_3000);
        chk("stall_pend0",   AW'(pending), 64'd0);
        tick();
        redir(2, 64'h8000_4000);
        #1;
        chk("stall_pend1",   AW'(pending), 64'd1);
        chk("stall_addr2",   req_addr, 64'h8000_4000);
        tick();
        redir_valid = '0;
        #1;
        chk("hold_pend",  AW'(pending), 64'd1);
        chk("hold_addr",  req_addr, 64'h8000_4000);
        chk("hold_pc",    pc, 64'h8000_1002);
        stall = 1'b0; req_ready = 1'b0;
        #1;
        chk("noready_valid", AW'(req_valid), 64'd1);
        tick();
        chk("noready_pend", AW'(pending), 64'd1);
        chk("noready_addr", req_addr, 64'h8000_4000);
        req_ready = 1'b1;
        tick();
        chk("release_pc",   pc, 64'h8000_4000);
        chk("release_pend", AW'(pending), 64'd0);
        chk("release_addr", req_addr, 64'h8000_4004);
        tick();
        chk("release_pc2", pc, 64'h8000_4004);

        redir(0, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        redir_valid = '0;
        #1;
        chk("wrap_pc",   pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", req_addr, 64'h0);
        tick();
        chk("wrap_pc2", pc, 64'h0);

        stall = 1'b1;
        redir(0, 64'h8000_5000);
        tick();
        redir_valid = '0;
        #1;
        chk("pre_rst_pend", AW'(pending), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pend",  AW'(pending), 64'd0);
        chk("midrst_pc",    pc, RST_A);
        chk("midrst_valid", AW'(req_valid), 64'd0);
        chk("midrst_addr",  req_addr, RST_A);
        tick();
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("postrst_addr",  req_addr, RST_A);
        chk("postrst_valid", AW'(req_valid), 64'd1);
        tick();
        chk("postrst_pc",    pc, RST_A);
        chk("postrst_addr2", req_addr, 64'h8000_0004);

        rst = 1'b1;
        tick();
        rst = 1'b0; req_ready = 1'b0;
        tick();
        chk("boot_hold_addr", req_addr, RST_A);
        chk("boot_hold_pend", AW'(pending), 64'd0);
        redir(2, 64'h8000_6000);
        #1;
        chk("boot_preempt", req_addr, 64'h8000_6000);
        tick();
        redir_valid = '0;
        #1;
        chk("boot_pend",      AW'(pending), 64'd1);
        chk("boot_pend_addr", req_addr, 64'h8000_6000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
